// File: rtl/icache_refill_if.sv
// Refill controller bus: the ICache request/response signals and the byte-wide RAM port.
// The master side is the ICache/RAM, the slave side is icache_refill.
// BLOCK_WIDTH must match the value given to the icache_refill instance.
interface icache_refill_if #(
  parameter int BLOCK_WIDTH = 2
) ();
  logic                            query_en;
  logic [29-BLOCK_WIDTH:0]         query_addr;
  logic                            busy;
  logic                            data_en;
  logic [(32<<BLOCK_WIDTH)-1:0]    data;
  logic [7:0]                      mem_din;
  logic [7:0]                      mem_dout;
  logic [31:0]                     mem_a;
  logic                            mem_wr;

  modport master (
    output query_en, query_addr, mem_din,
    input  busy, data_en, data, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  query_en, query_addr, mem_din,
    output busy, data_en, data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/icache_refill.sv
// ICache block refill: fetches one cache block byte-by-byte from a RAM with
// one cycle of read latency and assembles it little-endian.
// Optional feature macro: ICACHE_REFILL_QUEUE_EN adds a single pending-request
// slot so a query arriving during a refill is served right after it.
//
// state | meaning
// IDLE  | no refill; mem_a = 0; accepts a query (or the pending one)
// READ  | issuing addresses and capturing bytes; busy = 1
//
// While rdy_in is low the RAM port presents the oldest uncaptured byte, so its
// data is already valid on the first cycle rdy_in is back high.
module icache_refill #(
  parameter int BLOCK_WIDTH = 2,
  parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH,
  parameter int BYTE_CNT    = BLOCK_SIZE * 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  icache_refill_if.slave  bus
);

  localparam int IDX_W = BLOCK_WIDTH + 2;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [29-BLOCK_WIDTH:0] addr_q, addr_d;
  logic [CNT_W-1:0]        iss_q, iss_d;
  logic [CNT_W-1:0]        rcv_q, rcv_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [BYTE_CNT*8-1:0]   data_q, data_d;
  logic                    data_en_q, data_en_d;
  logic [IDX_W-1:0]        iss_idx;
`ifdef ICACHE_REFILL_QUEUE_EN
  logic                    pend_q, pend_d;
  logic [29-BLOCK_WIDTH:0] pend_addr_q, pend_addr_d;
`endif

  // State, counters, captured block and pending slot; reset wins over rdy_in
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      iss_q       <= '0;
      rcv_q       <= '0;
      rd_vld_q    <= 1'b0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
`ifdef ICACHE_REFILL_QUEUE_EN
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      iss_q       <= iss_d;
      rcv_q       <= rcv_d;
      rd_vld_q    <= rd_vld_d;
      data_q      <= data_d;
      data_en_q   <= data_en_d;
`ifdef ICACHE_REFILL_QUEUE_EN
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
`endif
    end
  end

  // Next-state: accept, issue/capture bytes, realign issue pointer while paused
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iss_d     = iss_q;
    rcv_d     = rcv_q;
    rd_vld_d  = rd_vld_q;
    data_d    = data_q;
    data_en_d = 1'b0;
`ifdef ICACHE_REFILL_QUEUE_EN
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
`endif
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          iss_d    = '0;
          rcv_d    = '0;
          rd_vld_d = 1'b0;
`ifdef ICACHE_REFILL_QUEUE_EN
          if (pend_q) begin
            state_d     = READ;
            addr_d      = pend_addr_q;
            pend_d      = bus.query_en;
            pend_addr_d = bus.query_addr;
          end else
`endif
          if (bus.query_en) begin
            state_d = READ;
            addr_d  = bus.query_addr;
          end
        end
        READ: begin
`ifdef ICACHE_REFILL_QUEUE_EN
          if (bus.query_en && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = bus.query_addr;
          end
`endif
          if (iss_q != CNT_W'(BYTE_CNT)) iss_d = iss_q + 1'b1;
          rd_vld_d = 1'b1;
          if (rd_vld_q) begin
            for (int i = 0; i < BYTE_CNT; i++) begin
              if (rcv_q[IDX_W-1:0] == IDX_W'(i)) data_d[i*8 +: 8] = bus.mem_din;
            end
            rcv_d = rcv_q + 1'b1;
            if (rcv_q == CNT_W'(BYTE_CNT-1)) begin
              state_d   = IDLE;
              data_en_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == READ) begin
      // The oldest uncaptured byte is on the bus now, so it counts as issued
      iss_d    = rcv_q + 1'b1;
      rd_vld_d = 1'b1;
    end
  end

  // Byte index on the RAM port: hold the last address at the end, oldest uncaptured while paused
  always_comb begin
    if (!rdy_in)                          iss_idx = rcv_q[IDX_W-1:0];
    else if (iss_q == CNT_W'(BYTE_CNT))   iss_idx = IDX_W'(BYTE_CNT-1);
    else                                  iss_idx = iss_q[IDX_W-1:0];
  end

  assign bus.mem_a    = (state_q == READ) ? {addr_q, iss_idx} : 32'd0;
  assign bus.busy     = (state_q == READ);
  assign bus.data_en  = data_en_q;
  assign bus.data     = data_q;
  assign bus.mem_dout = 8'd0;
  assign bus.mem_wr   = 1'b0;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: byte-addressed RAM model whose byte
// value is the low byte of its address, scoreboard of expected blocks and
// data_en cycles, plus per-cycle address/busy checks.
module tb_icache_refill;

  typedef struct {
    logic [127:0] d;
    int           c;
  } sb_t;

  logic clk_in;
  logic rst_in;
  logic rdy_in;
  int   cyc;
  int   n_chk;
  int   n_fail;
  sb_t  sb[$];

  icache_refill_if #(.BLOCK_WIDTH(2)) bus ();

  icache_refill #(.BLOCK_WIDTH(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM with one cycle of read latency
  always @(posedge clk_in) bus.mem_din <= bus.mem_a[7:0];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] blk(input logic [27:0] qa);
    logic [31:0]  b;
    logic [127:0] r;
    b = {qa, 4'b0};
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(b + k);
    return r;
  endfunction

  task automatic nxt();
    @(posedge clk_in);
    #1;
  endtask

  // Scoreboard consumer and write-port monitor
  always @(negedge clk_in) begin
    sb_t e;
    chk("wr_port_zero", {bus.mem_wr, bus.mem_dout}, 0);
    if (bus.data_en) begin
      if (sb.size() == 0) begin
        chk("spurious_data_en", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("blk_data", bus.data, e.d);
        chk("blk_cycle", cyc, e.c);
      end
    end
  end

  task automatic refill(input logic [27:0] qa, input int stall_c, input int stall_n,
                        input int pulse_c, input logic [27:0] qa2);
    int  a;
    int  idx;
    bit  stalled;
    sb_t e;
    a = cyc;
    bus.query_en   = 1'b1;
    bus.query_addr = qa;
    e.d = blk(qa);
    e.c = a + 18 + stall_n;
    sb.push_back(e);
    for (int c = 1; c <= 17 + stall_n; c++) begin
      nxt();
      bus.query_en = 1'b0;
      if (c == pulse_c) begin
        bus.query_en   = 1'b1;
        bus.query_addr = qa2;
`ifdef ICACHE_REFILL_QUEUE_EN
        e.d = blk(qa2);
        e.c = a + 36;
        sb.push_back(e);
`endif
      end
      stalled = (stall_n > 0) && (c >= stall_c) && (c < stall_c + stall_n);
      rdy_in  = !stalled;
      if (stalled)                                  idx = stall_c - 2;
      else if (stall_n > 0 && c >= stall_c + stall_n) idx = c - 1 - stall_n;
      else                                          idx = c - 1;
      if (idx > 15) idx = 15;
      #1;
      chk("busy_read", bus.busy, 1);
      chk("mem_a", bus.mem_a, {qa, 4'b0} + 32'(idx));
    end
    bus.query_en = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus.query_en   = 1'b0;
    bus.query_addr = '0;
    repeat (3) nxt();
    chk("rst_busy", bus.busy, 0);
    chk("rst_data_en", bus.data_en, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    rst_in = 1'b0;
    nxt();

    // Single refill at byte address 0x1000
    refill(28'h0000100, 0, 0, 0, 28'h0);
    nxt();
    chk("done_busy", bus.busy, 0);
    chk("done_mem_a", bus.mem_a, 0);
    chk("done_data_en", bus.data_en, 1);
    chk("word0", bus.data[31:0], 32'h03020100);
    chk("word3", bus.data[127:96], 32'h0F0E0D0C);

    // Back-to-back: new query in the data_en cycle
    refill(28'h0000123, 0, 0, 0, 28'h0);
    nxt();
    chk("b2b_busy", bus.busy, 0);
    nxt();

    // Pause for 3 cycles after byte 5 is captured
    refill(28'h0000100, 8, 3, 0, 28'h0);
    nxt();
    chk("stall_done_busy", bus.busy, 0);
    nxt();

    // Query pulsed in cycle 8 of a refill
    refill(28'h0000456, 0, 0, 8, 28'h0000789);
    nxt();
    chk("pulse_c18_busy", bus.busy, 0);
    nxt();
`ifdef ICACHE_REFILL_QUEUE_EN
    chk("queued_busy", bus.busy, 1);
    chk("queued_mem_a", bus.mem_a, 32'h00007890);
`else
    chk("dropped_busy", bus.busy, 0);
`endif
    repeat (21) nxt();
    chk("pulse_end_busy", bus.busy, 0);

    // Reset in cycle 10 of a refill, rdy_in low at the same time
    bus.query_en   = 1'b1;
    bus.query_addr = 28'h00000AB;
    nxt();
    bus.query_en = 1'b0;
    repeat (9) nxt();
    rst_in = 1'b1;
    rdy_in = 1'b0;
    nxt();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_data_en", bus.data_en, 0);
    chk("mid_rst_data", bus.data, 0);
    chk("mid_rst_mem_a", bus.mem_a, 0);
    repeat (40) nxt();
    chk("post_rst_busy", bus.busy, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
